// File: rtl/uart_alu_if.sv
// uart_alu_if: assembles 3-byte RX frames (A, B, opcode) for the ALU and pushes its result to TX.
// A partial frame that stalls for TMO_CYC idle clocks is discarded with a frame_err pulse.
module uart_alu_if #(
    parameter int NB_DATA  = 8,
    parameter int NB_CODE  = 6,
    parameter int NB_STATE = 2,
    parameter int TMO_CYC  = 1000000,
    parameter int NB_TMO   = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_empty,
    input  logic [NB_DATA-1:0] rx_data,
    output logic               rd_uart,
    input  logic               tx_full,
    output logic               wr_uart,
    output logic [NB_DATA-1:0] tx_data,
    output logic [NB_DATA-1:0] data_a,
    output logic [NB_DATA-1:0] data_b,
    output logic [NB_CODE-1:0] op_code,
    input  logic [NB_DATA-1:0] alu_result,
    output logic               frame_err
);
    typedef enum logic [NB_STATE-1:0] {GET_A = 2'b00, GET_B = 2'b01, GET_OP = 2'b10, SEND = 2'b11} state_t;

    localparam logic [NB_TMO-1:0] TMO_LAST = NB_TMO'(TMO_CYC - 1);

    state_t            state, state_next;
    logic [NB_TMO-1:0] tmo_cnt;
    logic              in_frame, tmo_hit;

    assign rd_uart  = ~reset & ~rx_empty & (state != SEND);
    assign in_frame = (state == GET_B) || (state == GET_OP);
    // a byte arriving on the terminal-count cycle is popped instead of discarding the frame
    assign tmo_hit  = in_frame && rx_empty && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_next = state;
        case (state)
            GET_A:   state_next = rd_uart ? GET_B : GET_A;
            GET_B:   state_next = rd_uart ? GET_OP : tmo_hit ? GET_A : GET_B;
            GET_OP:  state_next = rd_uart ? SEND : tmo_hit ? GET_A : GET_OP;
            default: state_next = tx_full ? SEND : GET_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= GET_A;
        else       state <= state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_a    <= '0;
            data_b    <= '0;
            op_code   <= '0;
            tx_data   <= '0;
            wr_uart   <= 1'b0;
            frame_err <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            wr_uart   <= (state == SEND) && !tx_full;
            frame_err <= tmo_hit;
            tmo_cnt   <= (in_frame && rx_empty && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
            if (rd_uart && state == GET_A) data_a <= rx_data;
            if (rd_uart && state == GET_B) data_b <= rx_data;
            if (rd_uart && state == GET_OP) op_code <= rx_data[NB_CODE-1:0];
            if (state == SEND && !tx_full) tx_data <= alu_result;
        end
    end
endmodule

// File: tb/tb_uart_alu_if.sv
// tb_uart_alu_if: directed frames through a byte-FIFO model and a small ALU model.
module tb_uart_alu_if;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty, rd_uart, tx_full, wr_uart, frame_err;
    logic [7:0] rx_data, tx_data, data_a, data_b, alu_result;
    logic [5:0] op_code;

    logic [7:0] mem [64];
    logic [7:0] tx_log [64];
    int wr_ptr = 0, rd_ptr = 0, rd_cnt = 0, wr_cnt = 0, fe_cnt = 0;
    int n_chk = 0, n_fail = 0;

    uart_alu_if #(.TMO_CYC(16), .NB_TMO(5)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .wr_uart(wr_uart), .tx_data(tx_data), .data_a(data_a), .data_b(data_b),
        .op_code(op_code), .alu_result(alu_result), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign rx_empty = (rd_ptr == wr_ptr);
    assign rx_data  = mem[rd_ptr];

    always_comb begin
        alu_result = 8'h00;
        case (op_code)
            6'h20: alu_result = data_a + data_b;
            6'h22: alu_result = data_a - data_b;
            6'h24: alu_result = data_a & data_b;
            6'h25: alu_result = data_a | data_b;
            default: alu_result = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (rd_uart && !rx_empty) rd_ptr <= rd_ptr + 1;
        if (rd_uart) rd_cnt <= rd_cnt + 1;
        if (wr_uart) begin
            tx_log[wr_cnt] <= tx_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic wait_wr(input int target, input string tag);
        int k = 0;
        while (wr_cnt < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, wr_cnt, target);
    endtask

    initial begin
        int w0, r0, f0, k;
        tx_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_a", data_a, 0);
        check("rst_op_code", op_code, 0);
        check("rst_wr", wr_uart, 0);
        check("rst_tx_data", tx_data, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: ADD with exact latency
        push(8'h05); push(8'h03); push(8'h20);
        repeat (3) @(negedge clk);
        check("t1_wr_early", wr_uart, 0);
        @(negedge clk);
        check("t1_wr", wr_uart, 1);
        check("t1_tx", tx_data, 8'h08);
        @(negedge clk);
        check("t1_wr_once", wr_uart, 0);
        check("t1_a", data_a, 8'h05);
        check("t1_b", data_b, 8'h03);
        check("t1_op", op_code, 6'h20);

        // 2: SUB then AND back-to-back
        w0 = wr_cnt; r0 = rd_cnt;
        push(8'h03); push(8'h05); push(8'h22);
        push(8'hF0); push(8'h3C); push(8'h24);
        repeat (30) @(negedge clk);
        check("t2_wr_n", wr_cnt - w0, 2);
        check("t2_rd_n", rd_cnt - r0, 6);
        check("t2_sub", tx_log[w0], 8'hFE);
        check("t2_and", tx_log[w0+1], 8'h30);

        // 3: OR held by TX backpressure, next frame waiting in RX
        w0 = wr_cnt; r0 = rd_cnt;
        tx_full = 1'b1;
        push(8'h0F); push(8'hF0); push(8'h25);
        push(8'h02); push(8'h03); push(8'h20);
        repeat (50) @(negedge clk);
        check("t3_hold_wr", wr_cnt - w0, 0);
        check("t3_hold_rd", rd_cnt - r0, 3);
        tx_full = 1'b0;
        wait_wr(w0 + 2, "t3_wr_n");
        check("t3_or", tx_log[w0], 8'hFF);
        check("t3_next", tx_log[w0+1], 8'h05);
        check("t3_rd_n", rd_cnt - r0, 6);

        // 4: timeout after a lone operand
        f0 = fe_cnt;
        push(8'h11);
        @(negedge clk);
        check("t4_a", data_a, 8'h11);
        k = 0;
        while (!frame_err && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t4_tmo_lat", k, 16);
        @(negedge clk);
        check("t4_fe_pulse", frame_err, 0);
        check("t4_fe_n", fe_cnt - f0, 1);
        check("t4_a_kept", data_a, 8'h11);
        w0 = wr_cnt;
        push(8'h01); push(8'h01); push(8'h20);
        wait_wr(w0 + 1, "t4_wr_n");
        check("t4_tx", tx_log[w0], 8'h02);

        // 5: asynchronous reset in GET_OP; queued byte survives
        push(8'hAA); push(8'hBB);
        repeat (2) @(negedge clk);
        check("t5_pre_a", data_a, 8'hAA);
        push(8'h02);
        #1 reset = 1'b1;
        #1;
        check("t5_a", data_a, 0);
        check("t5_b", data_b, 0);
        check("t5_op", op_code, 0);
        check("t5_tx", tx_data, 0);
        check("t5_rd", rd_uart, 0);
        @(negedge clk);
        reset = 1'b0;
        w0 = wr_cnt;
        push(8'h02); push(8'h20);
        wait_wr(w0 + 1, "t5_wr_n");
        check("t5_res", tx_log[w0], 8'h04);

        // 6: opcode upper bits ignored; byte on terminal count beats timeout
        w0 = wr_cnt;
        push(8'h07); push(8'h01); push(8'hE0);
        wait_wr(w0 + 1, "t6_wr_n");
        check("t6_op", op_code, 6'h20);
        check("t6_tx", tx_log[w0], 8'h08);
        f0 = fe_cnt;
        w0 = wr_cnt;
        push(8'h11);
        @(negedge clk);
        repeat (15) @(negedge clk);
        push(8'h22);
        @(negedge clk);
        check("t6_race_b", data_b, 8'h22);
        check("t6_race_fe", frame_err, 0);
        push(8'h20);
        wait_wr(w0 + 1, "t6_race_wr_n");
        check("t6_race_tx", tx_log[w0], 8'h33);
        check("t6_fe_n", fe_cnt - f0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
